// File: rtl/ddr3_cmd_pkg.sv
// Shared DDR3 command encodings and arbiter FSM state type.
package ddr3_cmd_pkg;

    typedef logic [3:0] cmd_t;

    // {csbar, rasbar, casbar, webar}
    localparam cmd_t CmdNop  = 4'b0111;
    localparam cmd_t CmdMrs  = 4'b0000;
    localparam cmd_t CmdPrea = 4'b0010;
    localparam cmd_t CmdRef  = 4'b0001;
    localparam cmd_t CmdZqcl = 4'b0110;

    localparam int unsigned RefPendW = 4;

    typedef enum logic [2:0] {
        StIdle,
        StRun,
        StPrea,
        StRpWait,
        StRef,
        StRfcWait
    } state_e;

endpackage

// File: rtl/ddr3_refresh_arbiter_if.sv
// User command port, DRAM command pins and refresh status of the refresh arbiter.
interface ddr3_refresh_arbiter_if;
    logic        init_ready;
    logic        user_req;
    logic [3:0]  user_cmd;
    logic [2:0]  user_ba;
    logic [13:0] user_a;
    logic        user_gnt;
    logic        csbar;
    logic        rasbar;
    logic        casbar;
    logic        webar;
    logic [2:0]  ba;
    logic [13:0] a;
    logic        ref_busy;
    logic [3:0]  ref_pend;

    modport slave (
        input  init_ready, user_req, user_cmd, user_ba, user_a,
        output user_gnt, csbar, rasbar, casbar, webar, ba, a, ref_busy, ref_pend
    );

    modport master (
        output init_ready, user_req, user_cmd, user_ba, user_a,
        input  user_gnt, csbar, rasbar, casbar, webar, ba, a, ref_busy, ref_pend
    );
endinterface

// File: rtl/ddr3_refi_timer.sv
// Refresh interval counter and saturating pending-refresh count.
module ddr3_refi_timer
    import ddr3_cmd_pkg::*;
#(
    parameter int unsigned T_REFI       = 3120,
    parameter int unsigned MAX_POSTPONE = 8
) (
    input  logic                clk,
    input  logic                resetbar,
    input  logic                i_enable,
    input  logic                i_dec,
    output logic                o_tick,
    output logic [RefPendW-1:0] o_ref_pend
);

    localparam int unsigned CntW = (T_REFI > 2) ? $clog2(T_REFI) : 1;

    logic [CntW-1:0]     r_cnt;
    logic [RefPendW-1:0] r_pend;
    logic                w_tick;
    logic                w_sat;

    always_comb begin
        w_tick = i_enable && (r_cnt == CntW'(T_REFI - 1));
        w_sat  = (r_pend >= RefPendW'(MAX_POSTPONE));
    end

    // Dropping enable (IDLE or init lost) clears both the interval and the backlog.
    always_ff @(posedge clk or negedge resetbar) begin
        if (!resetbar) begin
            r_cnt  <= '0;
            r_pend <= '0;
        end else if (!i_enable) begin
            r_cnt  <= '0;
            r_pend <= '0;
        end else begin
            r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
            if (w_tick && !i_dec) begin
                if (!w_sat) r_pend <= r_pend + 1'b1;
            end else if (i_dec && !w_tick && (r_pend != '0)) begin
                r_pend <= r_pend - 1'b1;
            end
        end
    end

    assign o_tick     = w_tick;
    assign o_ref_pend = r_pend;

endmodule

// File: rtl/ddr3_refresh_arbiter.sv
// Refresh/user command arbiter that owns the DDR3 pins after init.
// Optional feature: define REF_POSTPONE_EN to let user traffic defer refresh up to MAX_POSTPONE.
module ddr3_refresh_arbiter
    import ddr3_cmd_pkg::*;
#(
    parameter int unsigned T_REFI       = 3120,
    parameter int unsigned T_RP         = 6,
    parameter int unsigned T_RFC        = 44,
    parameter int unsigned MAX_POSTPONE = 8
) (
    input logic                   clk,
    input logic                   resetbar,
    ddr3_refresh_arbiter_if.slave bus
);

    localparam int unsigned WaitMax = (T_RFC > T_RP) ? T_RFC : T_RP;
    localparam int unsigned WaitW   = $clog2(WaitMax);

    state_e              r_state;
    logic [WaitW-1:0]    r_wait;
    cmd_t                r_cmd;
    logic [2:0]          r_ba;
    logic [13:0]         r_a;
    logic                r_gnt;
    logic                r_busy;
    cmd_t                r_hold_cmd;
    logic [2:0]          r_hold_ba;
    logic [13:0]         r_hold_a;

    logic [RefPendW-1:0] w_pend;
    logic                w_tick;
    logic                w_pend_nz;
    logic                w_ref_win_run;
    logic                w_start_prea;
    logic                w_start_ref;
    logic                w_timer_en;

    always_comb begin
        w_pend_nz = (w_pend != '0);
        // A granted user command owns the pins next cycle, so refresh waits one cycle.
`ifdef REF_POSTPONE_EN
        w_ref_win_run = w_pend_nz && !r_gnt &&
                        (!bus.user_req || (w_pend >= RefPendW'(MAX_POSTPONE)));
`else
        w_ref_win_run = w_pend_nz && !r_gnt;
`endif
        w_start_prea = bus.init_ready && (r_state == StRun) && w_ref_win_run;
        // Once a refresh burst has begun the whole backlog drains back-to-back.
        w_start_ref  = bus.init_ready && (r_state == StRfcWait) && (r_wait == '0) && w_pend_nz;
        w_timer_en   = bus.init_ready && (r_state != StIdle);
    end

    ddr3_refi_timer #(
        .T_REFI       (T_REFI),
        .MAX_POSTPONE (MAX_POSTPONE)
    ) u_refi_timer (
        .clk        (clk),
        .resetbar   (resetbar),
        .i_enable   (w_timer_en),
        .i_dec      (w_start_prea || w_start_ref),
        .o_tick     (w_tick),
        .o_ref_pend (w_pend)
    );

    always_ff @(posedge clk or negedge resetbar) begin
        if (!resetbar) begin
            r_state    <= StIdle;
            r_wait     <= '0;
            r_cmd      <= CmdNop;
            r_ba       <= '0;
            r_a        <= '0;
            r_gnt      <= 1'b0;
            r_busy     <= 1'b0;
            r_hold_cmd <= CmdNop;
            r_hold_ba  <= '0;
            r_hold_a   <= '0;
        end else begin
            r_cmd <= CmdNop;
            r_ba  <= '0;
            r_a   <= '0;
            r_gnt <= 1'b0;
            if (!bus.init_ready) begin
                r_state <= StIdle;
                r_wait  <= '0;
                r_busy  <= 1'b0;
            end else begin
                unique case (r_state)
                    StIdle: r_state <= StRun;
                    StRun: begin
                        if (r_gnt) begin
                            r_cmd <= r_hold_cmd;
                            r_ba  <= r_hold_ba;
                            r_a   <= r_hold_a;
                        end else if (w_ref_win_run) begin
                            r_state <= StPrea;
                            r_cmd   <= CmdPrea;
                            r_a     <= 14'h0400;
                            r_busy  <= 1'b1;
                        end else if (bus.user_req) begin
                            r_gnt      <= 1'b1;
                            r_hold_cmd <= bus.user_cmd;
                            r_hold_ba  <= bus.user_ba;
                            r_hold_a   <= bus.user_a;
                        end
                    end
                    StPrea: begin
                        r_state <= StRpWait;
                        r_wait  <= WaitW'(T_RP - 2);
                    end
                    StRpWait: begin
                        if (r_wait == '0) begin
                            r_state <= StRef;
                            r_cmd   <= CmdRef;
                        end else begin
                            r_wait <= r_wait - 1'b1;
                        end
                    end
                    StRef: begin
                        r_state <= StRfcWait;
                        r_wait  <= WaitW'(T_RFC - 2);
                    end
                    StRfcWait: begin
                        if (r_wait != '0) begin
                            r_wait <= r_wait - 1'b1;
                        end else if (w_start_ref) begin
                            r_state <= StRef;
                            r_cmd   <= CmdRef;
                        end else begin
                            r_state <= StRun;
                            r_busy  <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= StIdle;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.user_gnt = r_gnt;
    assign bus.csbar    = r_cmd[3];
    assign bus.rasbar   = r_cmd[2];
    assign bus.casbar   = r_cmd[1];
    assign bus.webar    = r_cmd[0];
    assign bus.ba       = r_ba;
    assign bus.a        = r_a;
    assign bus.ref_busy = r_busy;
    assign bus.ref_pend = w_pend;

endmodule
